// File: rtl/fm_rd_split_n.sv
// N-way read-burst splitter: one upstream read request becomes a run of sub-bursts of at most
// P_SUB_LEN words. Define FM_RD_SPLIT_N_ALIGN_EN to keep sub-bursts inside P_SUB_LEN-aligned blocks.
module fm_rd_split_n #(
    parameter int unsigned P_ADDR_WIDTH = 29,
    parameter int unsigned P_LEN_WIDTH  = 6,
    parameter int unsigned P_SUB_LOG2   = 4,
    parameter int unsigned P_SUB_LEN    = 16
) (
    input  logic                    clk_core,
    input  logic                    rst_x,
    input  logic                    i_req,
    input  logic [P_ADDR_WIDTH-1:0] i_adrs,
    input  logic [P_LEN_WIDTH-1:0]  i_len,
    output logic                    o_ack,
    output logic                    o_busy,
    output logic                    o_req,
    output logic [P_ADDR_WIDTH-1:0] o_adrs,
    output logic [P_LEN_WIDTH-1:0]  o_len,
    output logic                    o_first,
    output logic                    o_last,
    input  logic                    i_ack
);

    // A full-size piece length must fit in o_len.
    if ((P_LEN_WIDTH <= P_SUB_LOG2) || (P_SUB_LEN != (1 << P_SUB_LOG2))) begin : g_bad_params
        $error("fm_rd_split_n: inconsistent P_SUB_LEN/P_SUB_LOG2/P_LEN_WIDTH");
    end

    localparam logic [P_LEN_WIDTH-1:0] LP_SUB_LEN = P_LEN_WIDTH'(P_SUB_LEN);

    typedef enum logic {
        P_IDLE,
        P_ISSUE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [P_ADDR_WIDTH-1:0] r_adrs;
    logic [P_LEN_WIDTH-1:0]  r_rem;
    logic                    r_first;

    logic [P_LEN_WIDTH-1:0]  w_lim;
    logic [P_LEN_WIDTH-1:0]  w_piece;
    logic                    w_last;
    logic                    w_start;

`ifdef FM_RD_SPLIT_N_ALIGN_EN
    assign w_lim = LP_SUB_LEN - P_LEN_WIDTH'(r_adrs[P_SUB_LOG2-1:0]);
`else
    assign w_lim = LP_SUB_LEN;
`endif

    assign w_piece = (r_rem < w_lim) ? r_rem : w_lim;
    assign w_last  = (r_rem == w_piece);
    // Zero-length requests are acknowledged but never reach the downstream port.
    assign w_start = (r_state == P_IDLE) && i_req && (i_len != '0);

    always_ff @(posedge clk_core or negedge rst_x) begin
        if (!rst_x) begin
            r_state <= P_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            P_IDLE:  if (w_start) w_state_nxt = P_ISSUE;
            P_ISSUE: if (i_ack && w_last) w_state_nxt = P_IDLE;
            default: w_state_nxt = P_IDLE;
        endcase
    end

    always_ff @(posedge clk_core or negedge rst_x) begin
        if (!rst_x) begin
            r_adrs  <= '0;
            r_rem   <= '0;
            r_first <= 1'b0;
        end else if (w_start) begin
            r_adrs  <= i_adrs;
            r_rem   <= i_len;
            r_first <= 1'b1;
        end else if ((r_state == P_ISSUE) && i_ack) begin
            r_adrs  <= r_adrs + P_ADDR_WIDTH'(w_piece);
            r_rem   <= r_rem - w_piece;
            r_first <= 1'b0;
        end
    end

    always_comb begin
        o_ack   = 1'b0;
        o_busy  = 1'b0;
        o_req   = 1'b0;
        o_adrs  = '0;
        o_len   = '0;
        o_first = 1'b0;
        o_last  = 1'b0;
        case (r_state)
            P_IDLE: begin
                o_ack = i_req;
            end
            P_ISSUE: begin
                o_busy  = 1'b1;
                o_req   = 1'b1;
                o_adrs  = r_adrs;
                o_len   = w_piece;
                o_first = r_first;
                o_last  = w_last;
            end
            default: begin
                o_ack = 1'b0;
            end
        endcase
    end

endmodule
